pattern_seq_ctrl: RTL and testbench

PATTERN_SEQ_CTRL -- requirements
Module: pattern_seq_ctrl

---
 rtl/pattern_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pattern_seq_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_seq_ctrl.sv
// Pattern sequencer: steps an external pulse generator through a programmable
// table of settings, one entry at a time, for a fixed or unbounded number of passes.
module pattern_seq_ctrl #(
  parameter int DEPTH     = 4,
  parameter int PAT_WIDTH = 8,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [7:0]           cfg_duty,
  input  logic [15:0]          cfg_dessert,
  input  logic [7:0]           cfg_pulse_num,
  input  logic [PAT_WIDTH-1:0] cfg_pat,
  input  logic                 start,
  input  logic                 stop,
  input  logic [AW:0]          seq_len,
  input  logic [7:0]           loop_num,
  input  logic                 gen_busy,
  input  logic                 gen_valid,
  output logic                 gen_en,
  output logic [7:0]           gen_duty,
  output logic [15:0]          gen_dessert,
  output logic [7:0]           gen_pulse_num,
  output logic [PAT_WIDTH-1:0] gen_pat,
  output logic                 seq_busy,
  output logic                 seq_done,
  output logic [AW-1:0]        cur_idx,
  output logic                 err
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

  state_t               state_q, state_d;
  logic [AW-1:0]        idx_q;
  logic [AW:0]          len_q;
  logic [7:0]           loop_q;
  logic [7:0]           pass_q;
  logic                 abort_q;

  logic [7:0]           tbl_duty    [DEPTH];
  logic [15:0]          tbl_dessert [DEPTH];
  logic [7:0]           tbl_pulse   [DEPTH];
  logic [PAT_WIDTH-1:0] tbl_pat     [DEPTH];

  logic       len_ok, start_ok, last_entry, loop_hit, gen_idle, halt;
  logic [7:0] pass_inc;

  assign len_ok     = (seq_len != '0) && (seq_len <= LEN_MAX);
  assign start_ok   = start && !stop && len_ok;
  assign last_entry = ({1'b0, idx_q} == (len_q - LEN_ONE));
  assign pass_inc   = pass_q + 8'd1;
  // loop_num==0 runs forever, so the pass count is never compared then
  assign loop_hit   = (loop_q != 8'd0) && (pass_inc == loop_q);
  assign gen_idle   = !gen_busy && !gen_valid;
  assign halt       = abort_q || stop;
  assign cur_idx    = idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = LOAD;
      LOAD:    state_d = stop ? DONE : RUN;
      RUN:     if (stop || gen_valid) state_d = DRAIN;
      DRAIN: begin
        if (gen_idle) begin
          if (halt)                        state_d = DONE;
          else if (last_entry && loop_hit) state_d = DONE;
          else                             state_d = LOAD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    seq_busy = (state_q != IDLE);
    seq_done = (state_q == DONE);
  end

  // Table, drive registers and run bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_duty[i]    <= '0;
        tbl_dessert[i] <= '0;
        tbl_pulse[i]   <= '0;
        tbl_pat[i]     <= '0;
      end
      gen_en        <= 1'b0;
      gen_duty      <= '0;
      gen_dessert   <= '0;
      gen_pulse_num <= '0;
      gen_pat       <= '0;
      idx_q         <= '0;
      len_q         <= '0;
      loop_q        <= '0;
      pass_q        <= '0;
      abort_q       <= 1'b0;
      err           <= 1'b0;
    end else begin
      err <= (cfg_we && seq_busy) || (state_q == IDLE && start && !stop && !len_ok);
      if (cfg_we && !seq_busy) begin
        tbl_duty[cfg_addr]    <= cfg_duty;
        tbl_dessert[cfg_addr] <= cfg_dessert;
        tbl_pulse[cfg_addr]   <= cfg_pulse_num;
        tbl_pat[cfg_addr]     <= cfg_pat;
      end
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            idx_q   <= '0;
            pass_q  <= '0;
            len_q   <= seq_len;
            loop_q  <= loop_num;
            abort_q <= 1'b0;
          end
        end
        LOAD: begin
          if (!stop) begin
            gen_duty      <= tbl_duty[idx_q];
            gen_dessert   <= tbl_dessert[idx_q];
            gen_pulse_num <= tbl_pulse[idx_q];
            gen_pat       <= tbl_pat[idx_q];
            gen_en        <= 1'b1;
          end
        end
        RUN: begin
          if (stop || gen_valid) gen_en <= 1'b0;
          if (stop) abort_q <= 1'b1;
        end
        DRAIN: begin
          if (stop) abort_q <= 1'b1;
          if (gen_idle && !halt) begin
            if (!last_entry) begin
              idx_q <= idx_q + AW'(1);
            end else begin
              idx_q  <= '0;
              pass_q <= pass_inc;
            end
          end
        end
        DONE: begin
          gen_en  <= 1'b0;
          abort_q <= 1'b0;
        end
        default: gen_en <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// Directed bench for pattern_seq_ctrl with a small behavioural pulse generator
// whose valid/busy timing can be stretched per scenario.
module tb_pattern_seq_ctrl;

  localparam int DEPTH = 4;
  localparam int PW    = 8;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [7:0]    cfg_duty = '0;
  logic [15:0]   cfg_dessert = '0;
  logic [7:0]    cfg_pulse_num = '0;
  logic [PW-1:0] cfg_pat = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [AW:0]   seq_len = '0;
  logic [7:0]    loop_num = '0;
  logic          gen_busy, gen_valid;
  logic          gen_en;
  logic [7:0]    gen_duty;
  logic [15:0]   gen_dessert;
  logic [7:0]    gen_pulse_num;
  logic [PW-1:0] gen_pat;
  logic          seq_busy, seq_done, err;
  logic [AW-1:0] cur_idx;

  int errors = 0;
  int checks = 0;

  int run_cyc = 3;
  int vlen = 1;
  int tail = 0;
  int starts = 0;
  int g_phase = 0;
  int g_cnt = 0;
  logic [7:0] g_pn = '0;
  int idx_log [64];
  int pn_log  [64];
  int pat_log [64];

  pattern_seq_ctrl #(.DEPTH(DEPTH), .PAT_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_duty(cfg_duty),
    .cfg_dessert(cfg_dessert), .cfg_pulse_num(cfg_pulse_num), .cfg_pat(cfg_pat),
    .start(start), .stop(stop), .seq_len(seq_len), .loop_num(loop_num),
    .gen_busy(gen_busy), .gen_valid(gen_valid),
    .gen_en(gen_en), .gen_duty(gen_duty), .gen_dessert(gen_dessert),
    .gen_pulse_num(gen_pulse_num), .gen_pat(gen_pat),
    .seq_busy(seq_busy), .seq_done(seq_done), .cur_idx(cur_idx), .err(err)
  );

  always #5 clk = ~clk;

  // Generator: starts on gen_en while idle, runs run_cyc*pulse_num cycles,
  // holds valid for vlen cycles, keeps busy for tail more; pulse_num=0 runs until gen_en drops.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_busy  <= 1'b0;
      gen_valid <= 1'b0;
      g_phase   <= 0;
      g_cnt     <= 0;
    end else begin
      case (g_phase)
        0: if (gen_en) begin
          gen_busy <= 1'b1;
          g_phase  <= 1;
          g_pn     <= gen_pulse_num;
          g_cnt    <= run_cyc * int'(gen_pulse_num);
          if (starts < 64) begin
            idx_log[starts] <= int'(cur_idx);
            pn_log[starts]  <= int'(gen_pulse_num);
            pat_log[starts] <= int'(gen_pat);
          end
          starts <= starts + 1;
        end
        1: if (g_pn == 8'd0) begin
          if (!gen_en) begin g_phase <= 3; g_cnt <= 2; end
        end else if (g_cnt <= 1) begin
          gen_valid <= 1'b1; g_phase <= 2; g_cnt <= vlen;
        end else g_cnt <= g_cnt - 1;
        2: if (g_cnt <= 1) begin
          gen_valid <= 1'b0;
          if (tail == 0) begin gen_busy <= 1'b0; g_phase <= 0; end
          else begin g_phase <= 3; g_cnt <= tail; end
        end else g_cnt <= g_cnt - 1;
        default: if (g_cnt <= 1) begin gen_busy <= 1'b0; g_phase <= 0; end
                 else g_cnt <= g_cnt - 1;
      endcase
    end
  end

  task automatic cfg_write(input int a, input int d, input int ds, input int pn, input int pt);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_duty = 8'(d);
    cfg_dessert = 16'(ds); cfg_pulse_num = 8'(pn); cfg_pat = PW'(pt);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start(input int len, input int loops, input bit with_stop);
    start = 1'b1; stop = with_stop; seq_len = (AW+1)'(len); loop_num = 8'(loops);
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_gen_en(input int maxc, input string nm);
    int n = 0;
    while (gen_en !== 1'b1 && n < maxc) begin @(negedge clk); n++; end
    checks++;
    if (gen_en !== 1'b1) begin
      errors++; $display("FAIL %s: gen_en got %b expected 1 within %0d cycles", nm, gen_en, maxc);
    end
  endtask

  task automatic wait_done(input int maxc, input string nm, output int dcnt);
    int n = 0;
    dcnt = 0;
    while (dcnt == 0 && n < maxc) begin
      @(negedge clk); n++;
      if (seq_done === 1'b1) dcnt++;
    end
    checks++;
    if (dcnt == 0) begin errors++; $display("FAIL %s: seq_done got none expected one within %0d cycles", nm, maxc); end
    repeat (5) begin @(negedge clk); if (seq_done === 1'b1) dcnt++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (gen_en !== 1'b0) begin errors++; $display("FAIL reset_gen_en: got %b expected 0", gen_en); end
    checks++; if ({gen_duty, gen_dessert, gen_pulse_num, gen_pat} !== '0) begin
      errors++; $display("FAIL reset_gen_params: got %h expected 0", {gen_duty, gen_dessert, gen_pulse_num, gen_pat}); end
    checks++; if ({seq_busy, seq_done, err} !== 3'b000) begin
      errors++; $display("FAIL reset_status: got %b expected 000", {seq_busy, seq_done, err}); end
    checks++; if (cur_idx !== '0) begin errors++; $display("FAIL reset_cur_idx: got %0d expected 0", cur_idx); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL reset_idle: seq_busy got %b expected 0", seq_busy); end
  endtask

  task automatic test_sequence();
    int s0, dc;
    int exp_pn [3] = '{2, 1, 3};
    cfg_write(0, 8'h10, 16'h1000, 2, 8'hA0);
    cfg_write(1, 8'h11, 16'h1001, 1, 8'hA1);
    cfg_write(2, 8'h12, 16'h1002, 3, 8'hA2);
    s0 = starts;
    pulse_start(3, 2, 1'b0);
    checks++; if (seq_busy !== 1'b1) begin errors++; $display("FAIL seq_busy_after_start: got %b expected 1", seq_busy); end
    wait_done(3000, "seq_done_timeout", dc);
    checks++; if (dc != 1) begin errors++; $display("FAIL seq_done_count: got %0d expected 1", dc); end
    checks++; if (starts - s0 != 6) begin errors++; $display("FAIL seq_gen_starts: got %0d expected 6", starts - s0); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (idx_log[s0+k] != k % 3) begin
        errors++; $display("FAIL seq_idx_order[%0d]: got %0d expected %0d", k, idx_log[s0+k], k % 3); end
      checks++; if (pn_log[s0+k] != exp_pn[k % 3]) begin
        errors++; $display("FAIL seq_pulse_num[%0d]: got %0d expected %0d", k, pn_log[s0+k], exp_pn[k % 3]); end
    end
    checks++; if (seq_busy !== 1'b0 || cur_idx !== '0) begin
      errors++; $display("FAIL seq_end_state: busy/idx got %b/%0d expected 0/0", seq_busy, cur_idx); end
    checks++; if (gen_duty !== 8'h12 || gen_pat !== 8'hA2) begin
      errors++; $display("FAIL seq_params_held: duty/pat got %h/%h expected 12/a2", gen_duty, gen_pat); end
  endtask

  task automatic test_infinite();
    int s0, n, extra;
    cfg_write(0, 8'h33, 16'h3333, 0, 8'h3C);
    s0 = starts;
    pulse_start(1, 0, 1'b0);
    repeat (100) @(negedge clk);
    checks++; if (gen_en !== 1'b1 || gen_pat !== 8'h3C) begin
      errors++; $display("FAIL inf_running: gen_en/pat got %b/%h expected 1/3c", gen_en, gen_pat); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++; if (gen_en !== 1'b0) begin errors++; $display("FAIL inf_stop_gen_en: got %b expected 0", gen_en); end
    n = 0;
    while (seq_done !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++; if (seq_done !== 1'b1 || gen_busy !== 1'b0) begin
      errors++; $display("FAIL inf_done: seq_done/gen_busy got %b/%b expected 1/0", seq_done, gen_busy); end
    extra = 0;
    repeat (5) begin @(negedge clk); if (seq_done === 1'b1) extra++; end
    checks++; if (extra != 0) begin errors++; $display("FAIL inf_done_once: extra pulses got %0d expected 0", extra); end
    checks++; if (starts - s0 != 1) begin errors++; $display("FAIL inf_gen_starts: got %0d expected 1", starts - s0); end
  endtask

  task automatic test_bad_start();
    pulse_start(0, 1, 1'b0);
    checks++; if (err !== 1'b1 || seq_busy !== 1'b0) begin
      errors++; $display("FAIL bad_len0: err/busy got %b/%b expected 1/0", err, seq_busy); end
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_one_cycle: got %b expected 0", err); end
    pulse_start(DEPTH + 1, 1, 1'b0);
    checks++; if (err !== 1'b1 || seq_busy !== 1'b0) begin
      errors++; $display("FAIL bad_len_over: err/busy got %b/%b expected 1/0", err, seq_busy); end
    pulse_start(1, 1, 1'b1);
    checks++; if (err !== 1'b0 || seq_busy !== 1'b0) begin
      errors++; $display("FAIL start_stop_same: err/busy got %b/%b expected 0/0", err, seq_busy); end
    @(negedge clk);
    checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL start_stop_idle: busy got %b expected 0", seq_busy); end
  endtask

  task automatic test_cfg_busy();
    int s0, dc;
    cfg_write(0, 8'h01, 16'h0001, 1, 8'h50);
    cfg_write(1, 8'h02, 16'h0002, 1, 8'h11);
    cfg_write(2, 8'h03, 16'h0003, 1, 8'h52);
    s0 = starts;
    pulse_start(3, 2, 1'b0);
    wait_gen_en(20, "cfg_run_gen_en");
    cfg_write(1, 8'hEE, 16'hEEEE, 3, 8'hEE);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL cfg_busy_err: got %b expected 1", err); end
    pulse_start(1, 1, 1'b0);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL start_busy_no_err: got %b expected 0", err); end
    wait_done(3000, "cfg_done_timeout", dc);
    checks++; if (dc != 1) begin errors++; $display("FAIL cfg_done_count: got %0d expected 1", dc); end
    checks++; if (starts - s0 != 6) begin errors++; $display("FAIL cfg_gen_starts: got %0d expected 6", starts - s0); end
    checks++; if (pat_log[s0+1] != 8'h11 || pat_log[s0+4] != 8'h11) begin
      errors++; $display("FAIL cfg_entry1_kept: pat got %h/%h expected 11/11", pat_log[s0+1], pat_log[s0+4]); end
    checks++; if (pn_log[s0+4] != 1) begin errors++; $display("FAIL cfg_entry1_pn: got %0d expected 1", pn_log[s0+4]); end
  endtask

  task automatic test_drain_hold();
    int s0, dc;
    vlen = 2; tail = 1;
    cfg_write(0, 8'h60, 16'h0060, 1, 8'h60);
    cfg_write(1, 8'h61, 16'h0061, 1, 8'h61);
    s0 = starts;
    pulse_start(2, 1, 1'b0);
    wait_done(1000, "drain_done_timeout", dc);
    checks++; if (dc != 1) begin errors++; $display("FAIL drain_done_count: got %0d expected 1", dc); end
    checks++; if (starts - s0 != 2) begin errors++; $display("FAIL drain_gen_starts: got %0d expected 2", starts - s0); end
    checks++; if (idx_log[s0] != 0 || idx_log[s0+1] != 1) begin
      errors++; $display("FAIL drain_idx: got %0d,%0d expected 0,1", idx_log[s0], idx_log[s0+1]); end
    checks++; if (pat_log[s0] != 8'h60 || pat_log[s0+1] != 8'h61) begin
      errors++; $display("FAIL drain_pat: got %h,%h expected 60,61", pat_log[s0], pat_log[s0+1]); end
    vlen = 1; tail = 0;
  endtask

  task automatic test_async_reset();
    int s0, dc;
    cfg_write(0, 8'h55, 16'h5555, 0, 8'h5A);
    pulse_start(1, 0, 1'b0);
    wait_gen_en(20, "ar_gen_en");
    checks++; if (gen_duty !== 8'h55) begin errors++; $display("FAIL ar_loaded: duty got %h expected 55", gen_duty); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (gen_en !== 1'b0) begin errors++; $display("FAIL ar_gen_en_async: got %b expected 0", gen_en); end
    checks++; if ({gen_duty, gen_dessert, gen_pulse_num, gen_pat} !== '0) begin
      errors++; $display("FAIL ar_params: got %h expected 0", {gen_duty, gen_dessert, gen_pulse_num, gen_pat}); end
    checks++; if ({seq_busy, seq_done, err} !== 3'b000 || cur_idx !== '0) begin
      errors++; $display("FAIL ar_status: busy/done/err/idx got %b%b%b/%0d expected 000/0", seq_busy, seq_done, err, cur_idx); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    s0 = starts;
    pulse_start(1, 1, 1'b0);
    wait_gen_en(20, "ar_restart_gen_en");
    checks++; if ({gen_duty, gen_dessert, gen_pulse_num, gen_pat} !== '0 || cur_idx !== '0) begin
      errors++; $display("FAIL ar_zero_table: params/idx got %h/%0d expected 0/0",
                         {gen_duty, gen_dessert, gen_pulse_num, gen_pat}, cur_idx); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done(100, "ar_done_timeout", dc);
    checks++; if (dc != 1 || starts - s0 != 1) begin
      errors++; $display("FAIL ar_run: done/starts got %0d/%0d expected 1/1", dc, starts - s0); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_infinite();
    test_bad_start();
    test_cfg_busy();
    test_drain_hold();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
